// File: rtl/video_monitor.sv
// Video timing monitor: checks line width, line count and blanking during
// vertical sync, and publishes a per-frame checksum report on each vs falling edge.
//
// state     | meaning
// WAIT_SYNC | idle after reset, waiting for the first vs falling edge
// IN_FRAME  | accumulating the current frame, reporting on each vs falling edge
module video_monitor #(
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
  input  logic [23:0] rgb,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_cnt,
  output logic [31:0] checksum,
  output logic [10:0] lines,
  output logic [2:0]  err_flags
);

  localparam logic [11:0] HDISP_W = 12'(HDISP);
  localparam logic [10:0] VDISP_W = 11'(VDISP);

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    IN_FRAME  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        hs_q, vs_q;
  logic        hs_fall, vs_fall;
  logic        start_frame, publish;
  logic [11:0] pix_cnt, pix_nx;
  logic [31:0] acc, acc_nx;
  logic [10:0] line_cnt, line_nx;
  logic        err_w, err_s;
  logic        werr_nx, serr_nx;
  logic        line_close, line_live;
  logic [2:0]  flags_nx;

  assign hs_fall = hs_q & ~hs;
  assign vs_fall = vs_q & ~vs;

  // The pixel on the closing edge still belongs to the line/frame being closed,
  // so every close decision is taken on the post-increment values.
  assign line_close = hs_fall | vs_fall;
  assign pix_nx     = (blank && pix_cnt != 12'hFFF) ? pix_cnt + 12'd1 : pix_cnt;
  assign acc_nx     = acc + (blank ? {8'h00, rgb} : 32'h0000_0000);
  assign line_live  = line_close && (pix_nx != 12'd0);
  assign line_nx    = (line_live && line_cnt != 11'h7FF) ? line_cnt + 11'd1 : line_cnt;
  assign werr_nx    = err_w | (line_live && (pix_nx != HDISP_W));
  assign serr_nx    = err_s | (blank && !vs_q);
  assign flags_nx   = {serr_nx, (line_nx != VDISP_W), werr_nx};

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) state_q <= WAIT_SYNC;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    publish     = 1'b0;
    case (state_q)
      WAIT_SYNC: begin
        if (vs_fall) begin
          state_d     = IN_FRAME;
          start_frame = 1'b1;
        end
      end
      IN_FRAME: begin
        if (vs_fall) publish = 1'b1;
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_cnt  <= 16'd0;
      checksum   <= 32'd0;
      lines      <= 11'd0;
      err_flags  <= 3'd0;
      pix_cnt    <= 12'd0;
      acc        <= 32'd0;
      line_cnt   <= 11'd0;
      err_w      <= 1'b0;
      err_s      <= 1'b0;
    end else begin
      hs_q       <= hs;
      vs_q       <= vs;
      frame_done <= publish;
      if (publish) begin
        checksum  <= acc_nx;
        lines     <= line_nx;
        err_flags <= flags_nx;
        frame_ok  <= (flags_nx == 3'b000);
        frame_cnt <= frame_cnt + 16'd1;
      end
      // Clearing on the edge cycle makes the very next pixel part of the new frame.
      if (start_frame || publish) begin
        pix_cnt  <= 12'd0;
        acc      <= 32'd0;
        line_cnt <= 11'd0;
        err_w    <= 1'b0;
        err_s    <= 1'b0;
      end else if (state_q == IN_FRAME) begin
        pix_cnt  <= line_close ? 12'd0 : pix_nx;
        acc      <= acc_nx;
        line_cnt <= line_nx;
        err_w    <= werr_nx;
        err_s    <= serr_nx;
      end
    end
  end

endmodule

// File: tb/tb_video_monitor.sv
// Scoreboard bench for video_monitor: a full-size instance (161x90) and a small
// instance (20x16) share one timing generator; only the targeted instance is scored.
module tb_video_monitor;

  localparam int AH = 161, AV = 90;
  localparam int BH = 20,  BV = 16;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n = 1'b0;
  logic        hs = 1'b1, vs = 1'b1, blank = 1'b0;
  logic [23:0] rgb = 24'h0;

  logic        done_a, ok_a, done_b, ok_b;
  logic [15:0] cnt_out_a, cnt_out_b;
  logic [31:0] cs_a, cs_b;
  logic [10:0] ln_a, ln_b;
  logic [2:0]  err_a, err_b;

  video_monitor #(.HDISP(AH), .VDISP(AV)) dut_a (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .hs(hs), .vs(vs),
    .blank(blank), .rgb(rgb), .frame_done(done_a), .frame_ok(ok_a),
    .frame_cnt(cnt_out_a), .checksum(cs_a), .lines(ln_a), .err_flags(err_a));

  video_monitor #(.HDISP(BH), .VDISP(BV)) dut_b (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .hs(hs), .vs(vs),
    .blank(blank), .rgb(rgb), .frame_done(done_b), .frame_ok(ok_b),
    .frame_cnt(cnt_out_b), .checksum(cs_b), .lines(ln_b), .err_flags(err_b));

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic        ok;
    logic [15:0] cnt;
    logic [31:0] cs;
    logic [10:0] ln;
    logic [2:0]  err;
  } rep_t;

  rep_t qa[$], qb[$];
  int   checks = 0, failures = 0;
  bit   en_a = 0, en_b = 0;
  int   cnt_a = 0, cnt_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  // Scoreboard consumers for each instance
  always @(negedge pixel_clk) begin
    rep_t e;
    if (en_a && pixel_rst_n && done_a) begin
      checks++;
      if (prev_a !== 1'b0) begin failures++; $display("FAIL a_done_pulse got=two_cycles exp=one_cycle"); end
      if (qa.size() == 0) begin
        checks++; failures++; $display("FAIL a_unexpected_report frame_cnt=%0d exp=no_report", cnt_out_a);
      end else begin
        e = qa.pop_front();
        checks += 5;
        if (ok_a !== e.ok)       begin failures++; $display("FAIL a_frame_ok got=%0d exp=%0d", ok_a, e.ok); end
        if (cnt_out_a !== e.cnt) begin failures++; $display("FAIL a_frame_cnt got=%0d exp=%0d", cnt_out_a, e.cnt); end
        if (cs_a !== e.cs)       begin failures++; $display("FAIL a_checksum got=%0d exp=%0d", cs_a, e.cs); end
        if (ln_a !== e.ln)       begin failures++; $display("FAIL a_lines got=%0d exp=%0d", ln_a, e.ln); end
        if (err_a !== e.err)     begin failures++; $display("FAIL a_err_flags got=%b exp=%b", err_a, e.err); end
      end
    end
    if (en_b && pixel_rst_n && done_b) begin
      checks++;
      if (prev_b !== 1'b0) begin failures++; $display("FAIL b_done_pulse got=two_cycles exp=one_cycle"); end
      if (qb.size() == 0) begin
        checks++; failures++; $display("FAIL b_unexpected_report frame_cnt=%0d exp=no_report", cnt_out_b);
      end else begin
        e = qb.pop_front();
        checks += 5;
        if (ok_b !== e.ok)       begin failures++; $display("FAIL b_frame_ok got=%0d exp=%0d", ok_b, e.ok); end
        if (cnt_out_b !== e.cnt) begin failures++; $display("FAIL b_frame_cnt got=%0d exp=%0d", cnt_out_b, e.cnt); end
        if (cs_b !== e.cs)       begin failures++; $display("FAIL b_checksum got=%0d exp=%0d", cs_b, e.cs); end
        if (ln_b !== e.ln)       begin failures++; $display("FAIL b_lines got=%0d exp=%0d", ln_b, e.ln); end
        if (err_b !== e.err)     begin failures++; $display("FAIL b_err_flags got=%b exp=%b", err_b, e.err); end
      end
    end
    prev_a = done_a;
    prev_b = done_b;
  end

  task automatic cyc(input logic h, input logic v, input logic b, input logic [23:0] d);
    hs = h; vs = v; blank = b; rgb = b ? d : 24'h0;
    @(posedge pixel_clk); #1;
  endtask

  // hs low 2, back porch 2, npix pixels, front porch 2. vsa applies from pixel 1 on.
  task automatic gen_line(input int npix, input logic vss, input logic vsa, input logic [23:0] d);
    cyc(1'b0, vss, 1'b0, d); cyc(1'b0, vss, 1'b0, d);
    cyc(1'b1, vss, 1'b0, d); cyc(1'b1, vss, 1'b0, d);
    for (int i = 0; i < npix; i++) cyc(1'b1, (i == 0) ? vss : vsa, 1'b1, d);
    cyc(1'b1, vsa, 1'b0, d); cyc(1'b1, vsa, 1'b0, d);
  endtask

  task automatic gen_frame(input bit tgt, input int w, input int nl, input int bad_idx,
                           input int bad_w, input logic [23:0] d, input bit vs_pix);
    logic [31:0] cs = 32'h0;
    logic [2:0]  e  = 3'b000;
    int hd = tgt ? BH : AH;
    int vd = tgt ? BV : AV;
    int wl;
    rep_t r;
    gen_line(0, 1'b0, 1'b0, d);
    gen_line(0, 1'b0, 1'b0, d);
    if (vs_pix) gen_line(0, 1'b0, 1'b0, d);
    else        gen_line(0, 1'b1, 1'b1, d);
    for (int l = 0; l < nl; l++) begin
      wl = (l == bad_idx) ? bad_w : w;
      gen_line(wl, (vs_pix && l == 0) ? 1'b0 : 1'b1, 1'b1, d);
      cs = cs + 32'(wl) * {8'h00, d};
      if (wl != 0 && wl != hd) e[0] = 1'b1;
    end
    gen_line(0, 1'b1, 1'b1, d);
    if (nl != vd) e[1] = 1'b1;
    if (vs_pix)   e[2] = 1'b1;
    r.ok = (e == 3'b000); r.cs = cs; r.ln = 11'(nl); r.err = e;
    if (tgt) begin cnt_b++; r.cnt = 16'(cnt_b); qb.push_back(r); end
    else     begin cnt_a++; r.cnt = 16'(cnt_a); qa.push_back(r); end
  endtask

  task automatic gen_close();
    gen_line(0, 1'b0, 1'b0, 24'h0);
    gen_line(0, 1'b0, 1'b0, 24'h0);
    gen_line(0, 1'b1, 1'b1, 24'h0);
  endtask

  task automatic do_reset();
    pixel_rst_n = 1'b0;
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    pixel_rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if ({done_a, ok_a, cnt_out_a, cs_a, ln_a, err_a} !== '0) begin failures++; $display("FAIL rst_a_outputs got=%h exp=0", {done_a, ok_a, cnt_out_a, cs_a, ln_a, err_a}); end
    if ({done_b, ok_b, cnt_out_b, cs_b, ln_b, err_b} !== '0) begin failures++; $display("FAIL rst_b_outputs got=%h exp=0", {done_b, ok_b, cnt_out_b, cs_b, ln_b, err_b}); end
    if (cnt_out_a !== 16'd0) begin failures++; $display("FAIL rst_a_frame_cnt got=%0d exp=0", cnt_out_a); end
    if (cs_b !== 32'd0)      begin failures++; $display("FAIL rst_b_checksum got=%0d exp=0", cs_b); end
    if (qa.size() != 0)      begin failures++; $display("FAIL rst_qa_pending got=%0d exp=0", qa.size()); end
    if (qb.size() != 0)      begin failures++; $display("FAIL rst_qb_pending got=%0d exp=0", qb.size()); end
  endtask

  task automatic test_basic();
    en_a = 1;
    gen_frame(1'b0, AH, AV, -1, 0, 24'h000001, 1'b0);
    gen_frame(1'b0, AH, AV, -1, 0, 24'h000001, 1'b0);
  endtask

  task automatic test_width_err();
    gen_frame(1'b0, AH, AV, 10, AH - 1, 24'h000001, 1'b0);
    gen_close();
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    checks++;
    if (qa.size() != 0) begin failures++; $display("FAIL a_reports_missing got=%0d exp=0", qa.size()); end
    en_a = 0;
  endtask

  task automatic test_line_count();
    do_reset();
    en_b = 1;
    gen_frame(1'b1, BH, BV - 1, -1, 0, 24'h123456, 1'b0);
    gen_frame(1'b1, BH, BV, -1, 0, 24'h000102, 1'b0);
  endtask

  task automatic test_vs_blank();
    gen_frame(1'b1, BH, BV, -1, 0, 24'h00A0B0, 1'b1);
  endtask

  task automatic test_width_recovery();
    gen_frame(1'b1, BH, BV, 3, BH - 1, 24'h0000FF, 1'b0);
    gen_frame(1'b1, BH, BV, -1, 0, 24'h0000FF, 1'b0);
  endtask

  task automatic test_wrap();
    gen_frame(1'b1, BH, BV, -1, 0, 24'hFFFFFF, 1'b0);
    gen_frame(1'b1, BH, BV, -1, 0, 24'hFFFFFF, 1'b0);
  endtask

  task automatic test_reset_mid();
    gen_line(0, 1'b0, 1'b0, 24'h0);
    gen_line(0, 1'b0, 1'b0, 24'h0);
    gen_line(0, 1'b1, 1'b1, 24'h0);
    repeat (3) gen_line(BH, 1'b1, 1'b1, 24'h000003);
    pixel_rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 24'h000003);
    cyc(1'b1, 1'b1, 1'b1, 24'h000003);
    checks += 2;
    if ({done_b, ok_b, cnt_out_b, cs_b, ln_b, err_b} !== '0) begin failures++; $display("FAIL mid_rst_b_outputs got=%h exp=0", {done_b, ok_b, cnt_out_b, cs_b, ln_b, err_b}); end
    if (qb.size() != 0) begin failures++; $display("FAIL mid_rst_qb_pending got=%0d exp=0", qb.size()); end
    pixel_rst_n = 1'b1;
    cnt_b = 0;
    repeat (2) gen_line(BH, 1'b1, 1'b1, 24'h000003);
    gen_frame(1'b1, BH, BV, -1, 0, 24'h000007, 1'b0);
    gen_close();
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    checks += 2;
    if (qb.size() != 0)      begin failures++; $display("FAIL b_reports_missing got=%0d exp=0", qb.size()); end
    if (cnt_out_b !== 16'd1) begin failures++; $display("FAIL b_cnt_after_reset got=%0d exp=1", cnt_out_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width_err();
    test_line_count();
    test_vs_blank();
    test_width_recovery();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
